// File: rtl/uart_frame_checker_if.sv
// Byte stream from the UART receiver into the frame checker, and the checked
// frame, status pulses and counters going out to the register mapper.
interface uart_frame_checker_if #(
  parameter int FRAME_LEN = 12
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic [8*FRAME_LEN-1:0] frame_data;
  logic                   frame_valid;
  logic                   crc_err;
  logic                   timeout_err;
  logic                   busy;
  logic [15:0]            good_cnt;
  logic [15:0]            err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  frame_data, frame_valid, crc_err, timeout_err, busy, good_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output frame_data, frame_valid, crc_err, timeout_err, busy, good_cnt, err_cnt
  );
endinterface

// File: rtl/uart_frame_checker.sv
// Header hunt, fixed-length payload capture and CRC-8 (poly 0x07) check between
// the UART byte receiver and the register mapper; bad or stalled frames are dropped.
module uart_frame_checker #(
  parameter int         FRAME_LEN   = 12,
  parameter logic [7:0] HEAD_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  uart_frame_checker_if.slave bus
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int DW = 8 * FRAME_LEN;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic [IW-1:0]  idx_r;
  logic [7:0]     crc_r;
  logic [TW-1:0]  tmo_cnt_r;
  logic [DW-1:0]  shadow_r;

  logic [DW-1:0]  frame_data_r;
  logic           frame_valid_r;
  logic           crc_err_r;
  logic           timeout_err_r;
  logic           busy_r;
  logic [15:0]    good_cnt_r;
  logic [15:0]    err_cnt_r;

  logic           hdr_s;
  logic           take_s;
  logic           good_s;
  logic           bad_s;
  logic           tmo_s;
  logic           tmo_hit_s;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle frame events; a byte on the expiry cycle beats the timeout
  always_comb begin
    state_nxt_s = state_r;
    hdr_s       = 1'b0;
    take_s      = 1'b0;
    good_s      = 1'b0;
    bad_s       = 1'b0;
    tmo_s       = 1'b0;
    tmo_hit_s   = (tmo_cnt_r == TO_LAST) && !bus.rx_valid;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == HEAD_BYTE)) begin
          hdr_s       = 1'b1;
          state_nxt_s = ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          take_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else if (tmo_hit_s) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == crc_r) begin
            good_s = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Payload capture, running CRC and inter-byte idle counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_r     <= {IW{1'b0}};
      crc_r     <= 8'h00;
      tmo_cnt_r <= {TW{1'b0}};
      shadow_r  <= {DW{1'b0}};
    end else begin
      if (hdr_s) begin
        idx_r <= {IW{1'b0}};
        crc_r <= 8'h00;
      end else if (take_s) begin
        idx_r <= idx_r + IW'(1);
        crc_r <= crc8_update(crc_r, bus.rx_data);
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (idx_r == IW'(i)) begin
            shadow_r[i*8 +: 8] <= bus.rx_data;
          end
        end
      end
      if ((state_r == ST_IDLE) || bus.rx_valid || tmo_s) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
    end
  end

  // Registered result pulses, published frame and saturating counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_data_r  <= {DW{1'b0}};
      frame_valid_r <= 1'b0;
      crc_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      busy_r        <= 1'b0;
      good_cnt_r    <= 16'h0000;
      err_cnt_r     <= 16'h0000;
    end else begin
      frame_valid_r <= good_s;
      crc_err_r     <= bad_s;
      timeout_err_r <= tmo_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      if (good_s) begin
        frame_data_r <= shadow_r;
      end
      if (good_s && (good_cnt_r != 16'hFFFF)) begin
        good_cnt_r <= good_cnt_r + 16'd1;
      end
      if ((bad_s || tmo_s) && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign bus.frame_data  = frame_data_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.crc_err     = crc_err_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.busy        = busy_r;
  assign bus.good_cnt    = good_cnt_r;
  assign bus.err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed bench for uart_frame_checker: a 12-byte instance and a 9-byte instance,
// with expected frame results queued at stimulus time and popped on output pulses.
module tb_uart_frame_checker;

  localparam logic [2:0] K_GOOD = 3'b001;
  localparam logic [2:0] K_CRC  = 3'b010;
  localparam logic [2:0] K_TMO  = 3'b100;

  typedef struct packed {
    logic [2:0]  kind;
    logic [95:0] data;
  } exp_t;

  logic sys_clk;
  logic sys_rst_n;

  uart_frame_checker_if #(.FRAME_LEN(12)) bus_a ();
  uart_frame_checker_if #(.FRAME_LEN(9))  bus_b ();

  uart_frame_checker #(.FRAME_LEN(12), .HEAD_BYTE(8'hA5), .TIMEOUT_CYC(100)) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_a)
  );

  uart_frame_checker #(.FRAME_LEN(9), .HEAD_BYTE(8'hA5), .TIMEOUT_CYC(100)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_b)
  );

  int          checks;
  int          errors;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea;
  exp_t        eb;
  logic [7:0]  pl [12];
  logic [95:0] last_a, last_b;
  logic [15:0] good_a, err_a, good_b, err_b;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-8, poly 0x07, MSB first
  function automatic logic [7:0] crc_bits(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scoreboard for the 12-byte instance
  always @(negedge sys_clk) begin
    if (bus_a.frame_valid || bus_a.crc_err || bus_a.timeout_err) begin
      chk("a_result_expected", 128'(qa.size() != 0), 128'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_result_kind", 128'({bus_a.timeout_err, bus_a.crc_err, bus_a.frame_valid}), 128'(ea.kind));
        chk("a_frame_data", 128'(bus_a.frame_data), 128'(ea.data));
      end
    end
  end

  // Scoreboard for the 9-byte instance
  always @(negedge sys_clk) begin
    if (bus_b.frame_valid || bus_b.crc_err || bus_b.timeout_err) begin
      chk("b_result_expected", 128'(qb.size() != 0), 128'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_result_kind", 128'({bus_b.timeout_err, bus_b.crc_err, bus_b.frame_valid}), 128'(eb.kind));
        chk("b_frame_data", 128'(bus_b.frame_data), 128'(eb.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      bus_a.rx_data  = b;
      bus_a.rx_valid = 1'b1;
    end else begin
      bus_b.rx_data  = b;
      bus_b.rx_valid = 1'b1;
    end
    @(negedge sys_clk);
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  task automatic send_payload(input int sel, input int len, input int gap_at, input int gap_len);
    send_byte(sel, 8'hA5);
    if (sel == 0) chk("a_busy_after_header", 128'(bus_a.busy), 128'd1);
    else          chk("b_busy_after_header", 128'(bus_b.busy), 128'd1);
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) idle(gap_len);
      send_byte(sel, pl[i]);
    end
  endtask

  task automatic push_exp(input int sel, input logic bad, input int len);
    exp_t        e;
    logic [95:0] d;
    d = '0;
    for (int i = 0; i < len; i++) d[i*8 +: 8] = pl[i];
    if (sel == 0) begin
      if (bad) begin e.kind = K_CRC;  e.data = last_a; err_a = sat_inc(err_a); end
      else     begin e.kind = K_GOOD; e.data = d; last_a = d; good_a = sat_inc(good_a); end
      qa.push_back(e);
    end else begin
      if (bad) begin e.kind = K_CRC;  e.data = last_b; err_b = sat_inc(err_b); end
      else     begin e.kind = K_GOOD; e.data = d; last_b = d; good_b = sat_inc(good_b); end
      qb.push_back(e);
    end
  endtask

  task automatic send_frame(input int sel, input int len, input logic bad, input int gap_at, input int gap_len);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 0; i < len; i++) crc = crc_bits(crc, pl[i]);
    send_payload(sel, len, gap_at, gap_len);
    push_exp(sel, bad, len);
    send_byte(sel, bad ? (crc ^ 8'h01) : crc);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 12; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic chk_counts();
    chk("a_good_cnt", 128'(bus_a.good_cnt), 128'(good_a));
    chk("a_err_cnt",  128'(bus_a.err_cnt),  128'(err_a));
    chk("b_good_cnt", 128'(bus_b.good_cnt), 128'(good_b));
    chk("b_err_cnt",  128'(bus_b.err_cnt),  128'(err_b));
  endtask

  task automatic chk_reset_a();
    chk("a_rst_frame_data",  128'(bus_a.frame_data),  128'd0);
    chk("a_rst_frame_valid", 128'(bus_a.frame_valid), 128'd0);
    chk("a_rst_crc_err",     128'(bus_a.crc_err),     128'd0);
    chk("a_rst_timeout_err", 128'(bus_a.timeout_err), 128'd0);
    chk("a_rst_busy",        128'(bus_a.busy),        128'd0);
    chk("a_rst_good_cnt",    128'(bus_a.good_cnt),    128'd0);
    chk("a_rst_err_cnt",     128'(bus_a.err_cnt),     128'd0);
  endtask

  initial begin
    int k;
    logic hit;
    checks = 0;
    errors = 0;
    last_a = '0; last_b = '0;
    good_a = 16'd0; err_a = 16'd0; good_b = 16'd0; err_b = 16'd0;
    bus_a.rx_valid = 1'b0; bus_a.rx_data = 8'h00;
    bus_b.rx_valid = 1'b0; bus_b.rx_data = 8'h00;
    sys_rst_n = 1'b0;
    idle(3);
    chk_reset_a();
    chk("b_rst_busy", 128'(bus_b.busy), 128'd0);
    chk("b_rst_frame_data", 128'(bus_b.frame_data), 128'd0);
    sys_rst_n = 1'b1;
    idle(2);

    // All-zero frame: CRC 00
    for (int i = 0; i < 12; i++) pl[i] = 8'h00;
    send_frame(0, 12, 1'b0, -1, 0);
    chk("a_zero_frame_data", 128'(bus_a.frame_data), 128'd0);
    chk_counts();

    // Standard check value on the 9-byte instance, then the same frame with a bad CRC
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    send_payload(1, 9, -1, 0);
    push_exp(1, 1'b0, 9);
    send_byte(1, 8'hF4);
    chk("b_first_byte", 128'(bus_b.frame_data[7:0]), 128'h31);
    send_payload(1, 9, -1, 0);
    push_exp(1, 1'b1, 9);
    send_byte(1, 8'hF5);
    chk("b_first_byte_kept", 128'(bus_b.frame_data[7:0]), 128'h31);
    chk_counts();

    // Garbage before a header is ignored
    send_byte(0, 8'h00);
    chk("a_busy_garbage0", 128'(bus_a.busy), 128'd0);
    send_byte(0, 8'hFF);
    chk("a_busy_garbage1", 128'(bus_a.busy), 128'd0);
    send_byte(0, 8'h5A);
    chk("a_busy_garbage2", 128'(bus_a.busy), 128'd0);
    fill_rand();
    send_frame(0, 12, 1'b0, -1, 0);
    chk("a_busy_after_frame", 128'(bus_a.busy), 128'd0);
    chk_counts();

    // Header value inside the payload is plain data
    fill_rand();
    pl[0] = 8'hA5;
    pl[7] = 8'hA5;
    send_frame(0, 12, 1'b0, -1, 0);

    // Back-to-back frames with no idle cycles, second one corrupted, third good
    fill_rand();
    send_frame(0, 12, 1'b0, -1, 0);
    fill_rand();
    send_frame(0, 12, 1'b1, -1, 0);
    fill_rand();
    send_frame(0, 12, 1'b0, -1, 0);
    chk_counts();

    // Truncated frame: timeout exactly 100 cycles after the last strobe
    fill_rand();
    send_payload(0, 5, -1, 0);
    begin
      exp_t e;
      e.kind = K_TMO;
      e.data = last_a;
      qa.push_back(e);
      err_a = sat_inc(err_a);
    end
    k = 0;
    hit = 1'b0;
    while (!hit && (k < 200)) begin
      @(negedge sys_clk);
      k++;
      hit = bus_a.timeout_err;
    end
    chk("a_timeout_latency", 128'(k), 128'd100);
    chk("a_busy_after_timeout", 128'(bus_a.busy), 128'd0);
    chk_counts();
    fill_rand();
    send_frame(0, 12, 1'b0, -1, 0);
    chk_counts();

    // Byte arriving on the expiry cycle is accepted
    fill_rand();
    send_frame(0, 12, 1'b0, 4, 99);
    chk_counts();

    // Reset mid-frame aborts silently
    fill_rand();
    send_payload(0, 6, -1, 0);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk_reset_a();
    last_a = '0; last_b = '0;
    good_a = 16'd0; err_a = 16'd0; good_b = 16'd0; err_b = 16'd0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    fill_rand();
    send_frame(0, 12, 1'b0, -1, 0);
    chk("a_good_after_reset", 128'(bus_a.good_cnt), 128'd1);
    chk_counts();

    // Saturation: preload both counters to all-ones
    force dut_a.good_cnt_r = 16'hFFFF;
    force dut_a.err_cnt_r  = 16'hFFFF;
    @(negedge sys_clk);
    release dut_a.good_cnt_r;
    release dut_a.err_cnt_r;
    good_a = 16'hFFFF;
    err_a  = 16'hFFFF;
    fill_rand();
    send_frame(0, 12, 1'b0, -1, 0);
    fill_rand();
    send_frame(0, 12, 1'b1, -1, 0);
    chk("a_good_saturated", 128'(bus_a.good_cnt), 128'hFFFF);
    chk("a_err_saturated",  128'(bus_a.err_cnt),  128'hFFFF);

    idle(5);
    chk("a_queue_drained", 128'(qa.size()), 128'd0);
    chk("b_queue_drained", 128'(qb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
